// File: rtl/clkgen_monitor.sv
// Watches the divided clock set {clkf, clk2f, clk4f} as a modulo-8 counter stepping once per
// clk8f cycle, and reports lock, per-step error strobes, a saturating error count and phase.
module clkgen_monitor #(
    parameter int COUNT_DOWN  = 1,
    parameter int LOCK_CNT    = 8,
    parameter int UNLOCK_ERRS = 3,
    parameter int ERR_W       = 8
) (
    input  logic             clk8f,
    input  logic             reset,
    input  logic             clk4f_in,
    input  logic             clk2f_in,
    input  logic             clkf_in,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [2:0]       phase
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACQ,
        S_LOCKED
    } state_t;

    localparam logic [7:0] LOCK_LAST   = 8'(LOCK_CNT - 1);
    localparam logic [3:0] UNLOCK_LAST = 4'(UNLOCK_ERRS - 1);

    state_t           r_state;
    logic [7:0]       r_good_cnt;
    logic [3:0]       r_bad_run;
    logic [2:0]       r_last_q;
    logic             r_locked;
    logic             r_err_pulse;
    logic [ERR_W-1:0] r_err_count;
    logic [2:0]       r_phase;

    state_t           w_state_nxt;
    logic [7:0]       w_good_cnt_nxt;
    logic [3:0]       w_bad_run_nxt;
    logic             w_locked_nxt;
    logic             w_err_pulse_nxt;
    logic [ERR_W-1:0] w_err_count_nxt;
    logic [2:0]       w_phase_nxt;
    logic [2:0]       w_x;
    logic [2:0]       w_exp;
    logic             w_good;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign w_x    = {clkf_in, clk2f_in, clk4f_in};
    assign w_exp  = (COUNT_DOWN != 0) ? r_last_q - 3'd1 : r_last_q + 3'd1;
    assign w_good = (w_x == w_exp);

    always_comb begin
        w_state_nxt     = r_state;
        w_good_cnt_nxt  = r_good_cnt;
        w_bad_run_nxt   = r_bad_run;
        w_locked_nxt    = r_locked;
        w_err_pulse_nxt = 1'b0;
        w_err_count_nxt = r_err_count;
        w_phase_nxt     = r_phase;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_ACQ;
            end
            S_ACQ: begin
                if (!w_good) begin
                    w_good_cnt_nxt = '0;
                end else if (r_good_cnt == LOCK_LAST) begin
                    w_state_nxt    = S_LOCKED;
                    w_locked_nxt   = 1'b1;
                    w_good_cnt_nxt = '0;
                    w_bad_run_nxt  = '0;
                    w_phase_nxt    = w_x;
                end else begin
                    w_good_cnt_nxt = r_good_cnt + 8'd1;
                end
            end
            S_LOCKED: begin
                w_phase_nxt = w_x;
                if (w_good) begin
                    w_bad_run_nxt = '0;
                end else begin
                    w_err_pulse_nxt = 1'b1;
                    w_err_count_nxt = sat_inc(r_err_count);
                    // The final bad step of a run drops lock but still counts and strobes.
                    if (r_bad_run == UNLOCK_LAST) begin
                        w_state_nxt    = S_ACQ;
                        w_locked_nxt   = 1'b0;
                        w_phase_nxt    = '0;
                        w_good_cnt_nxt = '0;
                        w_bad_run_nxt  = '0;
                    end else begin
                        w_bad_run_nxt = r_bad_run + 4'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk8f) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_good_cnt  <= '0;
            r_bad_run   <= '0;
            r_last_q    <= '0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err_count <= '0;
            r_phase     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_good_cnt  <= w_good_cnt_nxt;
            r_bad_run   <= w_bad_run_nxt;
            r_last_q    <= w_x;
            r_locked    <= w_locked_nxt;
            r_err_pulse <= w_err_pulse_nxt;
            r_err_count <= w_err_count_nxt;
            r_phase     <= w_phase_nxt;
        end
    end

    assign locked    = r_locked;
    assign err_pulse = r_err_pulse;
    assign err_count = r_err_count;
    assign phase     = r_phase;

endmodule
